id_ex_stage: RTL and testbench

//  ID/EX pipeline register with integrated load-use hazard detection for the 5-stage MIPS pipeline.

---
 rtl/mips_pkg.sv | 20 ++
 rtl/hazard_detect_unit.sv | 32 +++
 rtl/id_ex_stage.sv | 148 ++++++++++++++
 tb/tb_id_ex_stage.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared pipeline types for the 5-stage MIPS core: decoded control bundle and
// register-specifier constants.
package mips_pkg;

  localparam int ALU_OP_W = 3;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic                reg_write;
    logic                mem_to_reg;
    logic                mem_read;
    logic                mem_write;
    logic                alu_src;
    logic                reg_dst;
    logic [ALU_OP_W-1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/hazard_detect_unit.sv
// Load-use hazard detection and PC / IF-ID write gating for the ID/EX boundary.
// Purely combinational; the raw load_use is reported before hold/flush priority.
module hazard_detect_unit (
  input  logic       hold,
  input  logic       flush,
  input  logic       IDEX_valid,
  input  logic       IDEX_mem_read,
  input  logic [4:0] IDEX_Rt,
  input  logic       ID_valid,
  input  logic       ID_uses_rt,
  input  logic [4:0] ID_Rs,
  input  logic [4:0] ID_Rt,
  output logic       load_use,
  output logic       pc_write,
  output logic       IFID_write
);
  import mips_pkg::*;

  logic rs_match;
  logic rt_match;

  assign rs_match = (IDEX_Rt == ID_Rs);
  assign rt_match = ID_uses_rt && (IDEX_Rt == ID_Rt);

  assign load_use = IDEX_valid && IDEX_mem_read && (IDEX_Rt != REG_ZERO) &&
                    ID_valid && (rs_match || rt_match);

  // A flush discards the dependent instruction anyway, so the front end keeps moving.
  assign pc_write   = !hold && (flush || !load_use);
  assign IFID_write = pc_write;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, hold/flush handling
// and a saturating count of load-use stalls.
module id_ex_stage #(
  parameter int WIDTH    = 32,
  parameter int ALU_OP_W = 3,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                hold,
  input  logic                flush,
  input  logic                ID_valid,
  input  logic                ID_reg_write,
  input  logic                ID_mem_to_reg,
  input  logic                ID_mem_read,
  input  logic                ID_mem_write,
  input  logic                ID_alu_src,
  input  logic                ID_reg_dst,
  input  logic [ALU_OP_W-1:0] ID_alu_op,
  input  logic                ID_uses_rt,
  input  logic [4:0]          ID_Rs,
  input  logic [4:0]          ID_Rt,
  input  logic [4:0]          ID_Rd,
  input  logic [WIDTH-1:0]    ID_read_data1,
  input  logic [WIDTH-1:0]    ID_read_data2,
  input  logic [WIDTH-1:0]    ID_imm,
  input  logic [WIDTH-1:0]    ID_pc_plus4,
  output logic                IDEX_valid,
  output logic                IDEX_reg_write,
  output logic                IDEX_mem_to_reg,
  output logic                IDEX_mem_read,
  output logic                IDEX_mem_write,
  output logic                IDEX_alu_src,
  output logic                IDEX_reg_dst,
  output logic [ALU_OP_W-1:0] IDEX_alu_op,
  output logic [4:0]          IDEX_Rs,
  output logic [4:0]          IDEX_Rt,
  output logic [4:0]          IDEX_Rd,
  output logic [WIDTH-1:0]    IDEX_read_data1,
  output logic [WIDTH-1:0]    IDEX_read_data2,
  output logic [WIDTH-1:0]    IDEX_imm,
  output logic [WIDTH-1:0]    IDEX_pc_plus4,
  output logic                pc_write,
  output logic                IFID_write,
  output logic [CNT_W-1:0]    stall_cnt
);
  import mips_pkg::*;

  ctrl_t            ctrl_q;
  ctrl_t            ctrl_d;
  logic             valid_q;
  logic [4:0]       rs_q, rt_q, rd_q;
  logic [WIDTH-1:0] rd1_q, rd2_q, imm_q, pc4_q;
  logic [CNT_W-1:0] cnt_q;
  logic             load_use;
  logic             bubble;
  logic             count_stall;

  hazard_detect_unit u_hazard (
    .hold          (hold),
    .flush         (flush),
    .IDEX_valid    (valid_q),
    .IDEX_mem_read (ctrl_q.mem_read),
    .IDEX_Rt       (rt_q),
    .ID_valid      (ID_valid),
    .ID_uses_rt    (ID_uses_rt),
    .ID_Rs         (ID_Rs),
    .ID_Rt         (ID_Rt),
    .load_use      (load_use),
    .pc_write      (pc_write),
    .IFID_write    (IFID_write)
  );

  assign ctrl_d = '{reg_write:  ID_reg_write,
                    mem_to_reg: ID_mem_to_reg,
                    mem_read:   ID_mem_read,
                    mem_write:  ID_mem_write,
                    alu_src:    ID_alu_src,
                    reg_dst:    ID_reg_dst,
                    alu_op:     ID_alu_op};

  assign bubble      = flush || load_use;
  assign count_stall = !flush && load_use && (cnt_q != {CNT_W{1'b1}});

  // ID -> EX register boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= CTRL_NOP;
      rs_q    <= REG_ZERO;
      rt_q    <= REG_ZERO;
      rd_q    <= REG_ZERO;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      pc4_q   <= '0;
    end else if (!hold) begin
      if (bubble) begin
        // Zeroed specifiers keep forwarding from matching against the bubble.
        valid_q <= 1'b0;
        ctrl_q  <= CTRL_NOP;
        rs_q    <= REG_ZERO;
        rt_q    <= REG_ZERO;
        rd_q    <= REG_ZERO;
        rd1_q   <= '0;
        rd2_q   <= '0;
        imm_q   <= '0;
        pc4_q   <= '0;
      end else begin
        valid_q <= ID_valid;
        ctrl_q  <= ctrl_d;
        rs_q    <= ID_Rs;
        rt_q    <= ID_Rt;
        rd_q    <= ID_Rd;
        rd1_q   <= ID_read_data1;
        rd2_q   <= ID_read_data2;
        imm_q   <= ID_imm;
        pc4_q   <= ID_pc_plus4;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!hold && count_stall) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign IDEX_valid      = valid_q;
  assign IDEX_reg_write  = ctrl_q.reg_write;
  assign IDEX_mem_to_reg = ctrl_q.mem_to_reg;
  assign IDEX_mem_read   = ctrl_q.mem_read;
  assign IDEX_mem_write  = ctrl_q.mem_write;
  assign IDEX_alu_src    = ctrl_q.alu_src;
  assign IDEX_reg_dst    = ctrl_q.reg_dst;
  assign IDEX_alu_op     = ctrl_q.alu_op;
  assign IDEX_Rs         = rs_q;
  assign IDEX_Rt         = rt_q;
  assign IDEX_Rd         = rd_q;
  assign IDEX_read_data1 = rd1_q;
  assign IDEX_read_data2 = rd2_q;
  assign IDEX_imm        = imm_q;
  assign IDEX_pc_plus4   = pc4_q;
  assign stall_cnt       = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed hazard scenarios plus random
// traffic compared against a cycle-level reference model of the stage.
module tb_id_ex_stage;
  localparam int WIDTH = 32;
  localparam int AW    = 3;
  localparam int CW    = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic hold = 1'b0, flush = 1'b0;
  logic ID_valid = 1'b0, ID_reg_write = 1'b0, ID_mem_to_reg = 1'b0, ID_mem_read = 1'b0;
  logic ID_mem_write = 1'b0, ID_alu_src = 1'b0, ID_reg_dst = 1'b0, ID_uses_rt = 1'b0;
  logic [AW-1:0] ID_alu_op = '0;
  logic [4:0] ID_Rs = '0, ID_Rt = '0, ID_Rd = '0;
  logic [WIDTH-1:0] ID_read_data1 = '0, ID_read_data2 = '0, ID_imm = '0, ID_pc_plus4 = '0;

  logic IDEX_valid, IDEX_reg_write, IDEX_mem_to_reg, IDEX_mem_read;
  logic IDEX_mem_write, IDEX_alu_src, IDEX_reg_dst;
  logic [AW-1:0] IDEX_alu_op;
  logic [4:0] IDEX_Rs, IDEX_Rt, IDEX_Rd;
  logic [WIDTH-1:0] IDEX_read_data1, IDEX_read_data2, IDEX_imm, IDEX_pc_plus4;
  logic pc_write, IFID_write;
  logic [CW-1:0] stall_cnt;

  id_ex_stage #(.WIDTH(WIDTH), .ALU_OP_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush),
    .ID_valid(ID_valid), .ID_reg_write(ID_reg_write), .ID_mem_to_reg(ID_mem_to_reg),
    .ID_mem_read(ID_mem_read), .ID_mem_write(ID_mem_write), .ID_alu_src(ID_alu_src),
    .ID_reg_dst(ID_reg_dst), .ID_alu_op(ID_alu_op), .ID_uses_rt(ID_uses_rt),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd),
    .ID_read_data1(ID_read_data1), .ID_read_data2(ID_read_data2),
    .ID_imm(ID_imm), .ID_pc_plus4(ID_pc_plus4),
    .IDEX_valid(IDEX_valid), .IDEX_reg_write(IDEX_reg_write),
    .IDEX_mem_to_reg(IDEX_mem_to_reg), .IDEX_mem_read(IDEX_mem_read),
    .IDEX_mem_write(IDEX_mem_write), .IDEX_alu_src(IDEX_alu_src),
    .IDEX_reg_dst(IDEX_reg_dst), .IDEX_alu_op(IDEX_alu_op),
    .IDEX_Rs(IDEX_Rs), .IDEX_Rt(IDEX_Rt), .IDEX_Rd(IDEX_Rd),
    .IDEX_read_data1(IDEX_read_data1), .IDEX_read_data2(IDEX_read_data2),
    .IDEX_imm(IDEX_imm), .IDEX_pc_plus4(IDEX_pc_plus4),
    .pc_write(pc_write), .IFID_write(IFID_write), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: the instruction sitting in EX, as plain fields.
  typedef struct packed {
    logic valid, reg_write, mem_to_reg, mem_read, mem_write, alu_src, reg_dst;
    logic [AW-1:0] alu_op;
    logic [4:0] rs, rt, rd;
    logic [WIDTH-1:0] rd1, rd2, imm, pc4;
  } ex_t;

  ex_t m_ex;
  int  m_cnt;
  int  n_cmp = 0;
  int  n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic ex_t from_id();
    ex_t e;
    e = '{valid: ID_valid, reg_write: ID_reg_write, mem_to_reg: ID_mem_to_reg,
          mem_read: ID_mem_read, mem_write: ID_mem_write, alu_src: ID_alu_src,
          reg_dst: ID_reg_dst, alu_op: ID_alu_op, rs: ID_Rs, rt: ID_Rt, rd: ID_Rd,
          rd1: ID_read_data1, rd2: ID_read_data2, imm: ID_imm, pc4: ID_pc_plus4};
    return e;
  endfunction

  // Does the instruction in ID need a value the load in EX has not produced yet?
  function automatic bit model_load_use();
    bit reads_loaded;
    reads_loaded = (ID_Rs == m_ex.rt) || (ID_uses_rt && ID_Rt == m_ex.rt);
    return m_ex.valid && m_ex.mem_read && m_ex.rt != 0 && ID_valid && reads_loaded;
  endfunction

  task automatic check_ex(input string p);
    chk({p, "_valid"}, IDEX_valid, m_ex.valid);
    chk({p, "_ctrl"}, {IDEX_reg_write, IDEX_mem_to_reg, IDEX_mem_read, IDEX_mem_write,
                       IDEX_alu_src, IDEX_reg_dst, IDEX_alu_op},
        {m_ex.reg_write, m_ex.mem_to_reg, m_ex.mem_read, m_ex.mem_write,
         m_ex.alu_src, m_ex.reg_dst, m_ex.alu_op});
    chk({p, "_regs"}, {IDEX_Rs, IDEX_Rt, IDEX_Rd}, {m_ex.rs, m_ex.rt, m_ex.rd});
    chk({p, "_data12"}, {IDEX_read_data1, IDEX_read_data2}, {m_ex.rd1, m_ex.rd2});
    chk({p, "_immpc"}, {IDEX_imm, IDEX_pc_plus4}, {m_ex.imm, m_ex.pc4});
    chk({p, "_cnt"}, stall_cnt, m_cnt);
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic cycle(input string p);
    bit lu, exp_pw;
    #1;
    lu = model_load_use();
    exp_pw = hold ? 1'b0 : (flush ? 1'b1 : !lu);
    chk({p, "_pc_write"}, pc_write, exp_pw);
    chk({p, "_ifid_write"}, IFID_write, exp_pw);
    @(posedge clk);
    if (!hold) begin
      if (flush || lu) m_ex = '0;
      else m_ex = from_id();
      if (!flush && lu && m_cnt < (1 << CW) - 1) m_cnt++;
    end
    #1;
    check_ex(p);
    @(negedge clk);
  endtask

  task automatic set_id(input bit v, input bit rw, input bit m2r, input bit mr,
                        input bit mw, input bit as, input bit rdst, input int op,
                        input bit ut, input int rs, input int rt, input int rd);
    ID_valid = v; ID_reg_write = rw; ID_mem_to_reg = m2r; ID_mem_read = mr;
    ID_mem_write = mw; ID_alu_src = as; ID_reg_dst = rdst; ID_alu_op = AW'(op);
    ID_uses_rt = ut; ID_Rs = 5'(rs); ID_Rt = 5'(rt); ID_Rd = 5'(rd);
    ID_read_data1 = $urandom; ID_read_data2 = $urandom;
    ID_imm = $urandom; ID_pc_plus4 = {$urandom_range(0, 1023), 2'b00};
  endtask

  task automatic lw(input int rt, input int rs);
    set_id(1, 1, 1, 1, 0, 1, 0, 0, 0, rs, rt, 0);
  endtask

  task automatic add(input int rd, input int rs, input int rt);
    set_id(1, 1, 0, 0, 0, 0, 1, 2, 1, rs, rt, rd);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_ex = '0;
    m_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int stalls_seen;

  initial begin
    m_ex = '0;
    m_cnt = 0;
    @(negedge clk);
    #1;
    check_ex("rst");
    chk("rst_pc_write", pc_write, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // lw $8,0($1); add $9,$8,$2 -> one bubble, then the add issues
    lw(8, 1);              cycle("lw1");
    add(9, 8, 2);          cycle("lu_stall");
    chk("lu_bubble_valid", IDEX_valid, 0);
    chk("lu_bubble_rw", IDEX_reg_write, 0);
    cycle("lu_issue");
    chk("lu_issue_rs", IDEX_Rs, 8);
    chk("lu_issue_valid", IDEX_valid, 1);
    chk("lu_issue_cnt", stall_cnt, 1);

    // addi $8,$3,4 after lw $8: Rt matches but is not read
    lw(8, 1);              cycle("lw2");
    set_id(1, 1, 0, 0, 0, 1, 0, 0, 0, 3, 8, 0);
    cycle("addi");
    chk("addi_valid", IDEX_valid, 1);
    chk("addi_cnt", stall_cnt, 1);
    // lw $0 then add $9,$0,$0
    lw(0, 1);              cycle("lw0");
    add(9, 0, 0);          cycle("add0");
    chk("add0_valid", IDEX_valid, 1);

    // load-use coinciding with flush
    lw(8, 1);              cycle("lw3");
    add(9, 8, 2); flush = 1'b1;
    cycle("flush_lu");
    flush = 1'b0;
    chk("flush_valid", IDEX_valid, 0);
    chk("flush_cnt", stall_cnt, 1);

    // hold for 3 cycles over a pending load-use
    lw(8, 1);              cycle("lw4");
    add(9, 2, 8); hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle("hold");
      chk("hold_frozen_rt", {IDEX_mem_read, IDEX_Rt}, {1'b1, 5'd8});
    end
    hold = 1'b0;
    cycle("hold_bubble");
    chk("hold_bubble_valid", IDEX_valid, 0);
    cycle("hold_issue");
    chk("hold_issue_rt", {IDEX_valid, IDEX_Rt}, {1'b1, 5'd8});
    chk("hold_issue_cnt", stall_cnt, 2);

    // reset asserted in the middle of a stall cycle
    lw(8, 1);              cycle("lw5");
    add(9, 8, 2);
    #2;
    chk("pre_rst_pc_write", pc_write, 0);
    rst_n = 1'b0;
    m_ex = '0;
    m_cnt = 0;
    #1;
    chk("midrst_valid", IDEX_valid, 0);
    chk("midrst_rs", IDEX_Rs, 0);
    chk("midrst_cnt", stall_cnt, 0);
    chk("midrst_pc_write", pc_write, 1);
    chk("midrst_ifid_write", IFID_write, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // lw $8,0($8) repeated: stalls every other cycle, drives the counter to saturation
    stalls_seen = 0;
    lw(8, 8);
    for (int i = 0; i < 2 * ((1 << CW) + 5) + 2; i++) begin
      if (model_load_use()) stalls_seen++;
      cycle("sat");
    end
    chk("sat_stalls_ge", stalls_seen >= (1 << CW) + 5, 1);
    chk("sat_cnt", stall_cnt, {CW{1'b1}});

    // random traffic with a narrow register range to provoke hazards
    do_reset();
    for (int i = 0; i < 600; i++) begin
      set_id($urandom_range(0, 7) != 0, $urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 31));
      hold  = ($urandom_range(0, 9) == 0);
      flush = ($urandom_range(0, 9) == 0);
      cycle("rnd");
      if (i == 300) do_reset();
    end
    hold = 1'b0;
    flush = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
